// File: rtl/decode_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : decode_sequencer
//  Description : Instruction decode and phase sequencer. Runs a
//                FETCH / E1 / E2 / MULW / HALT state machine, latches the
//                instruction word into IR on the FETCH->E1 edge and decodes
//                the control strobes for the datapath from state and IR.
//  Revision    : 1.0 - initial release
// ============================================================================
module decode_sequencer #(
  parameter int DATA_W  = 16,
  parameter int MUL_LAT = 4,
  parameter int NREG    = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [15:0]       instr,
  input  logic              eq_flag,
  input  logic              mem_ready,
  output logic              fe,
  output logic              e1,
  output logic              e2,
  output logic              instr_rden,
  output logic              pc_cnten,
  output logic              pc_sload,
  output logic              data_wren,
  output logic              mux1_sel,
  output logic              mux2_sel,
  output logic              extra1,
  output logic [NREG-1:0]   reg_en,
  output logic [DATA_W-1:0] imm,
  output logic [1:0]        out_sel,
  output logic              halted
);

  typedef enum logic [2:0] {
    S_FETCH = 3'd0,
    S_E1    = 3'd1,
    S_E2    = 3'd2,
    S_MULW  = 3'd3,
    S_HALT  = 3'd4
  } state_t;

  // mlr needs extra MULW cycles only when its latency exceeds one cycle
  localparam bit         C_MUL_MULTI = (MUL_LAT > 1);
  // MULW counter value on the final multiply cycle (counter starts at 1)
  localparam logic [3:0] C_LAST_CNT  = 4'(MUL_LAT - 1);

  state_t      state_q;
  logic [15:0] ir_q;
  logic [3:0]  cnt_q;

  // Opcode decode, always taken from the latched IR
  logic [4:0] w_op;
  logic       w_is_stp, w_is_mlr, w_is_ldr, w_is_ldi, w_is_sta, w_is_lda;
  logic       w_is_jmr, w_is_jmp, w_is_jeq, w_is_jnq, w_is_jump;
  logic       w_mul_last;

  assign w_op      = ir_q[15:11];
  assign w_is_stp  = (w_op == 5'b00000);
  assign w_is_mlr  = (w_op == 5'b00111);
  assign w_is_ldr  = (w_op == 5'b01110);
  assign w_is_ldi  = (w_op[4:2] == 3'b100);
  assign w_is_sta  = (w_op[4:2] == 3'b101);
  assign w_is_lda  = (w_op[4:2] == 3'b110);
  assign w_is_jmr  = (w_op == 5'b11100);
  assign w_is_jmp  = (w_op == 5'b11101);
  assign w_is_jeq  = (w_op == 5'b11110);
  assign w_is_jnq  = (w_op == 5'b11111);
  assign w_is_jump = (w_op[4:2] == 3'b111);
  assign w_mul_last = (cnt_q == C_LAST_CNT);

  // Phase sequencing, IR capture and multiply-latency counter
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
      ir_q    <= 16'h0000;
      cnt_q   <= 4'd0;
    end else begin
      case (state_q)
        S_FETCH: begin
          ir_q    <= instr;
          state_q <= S_E1;
        end
        S_E1: begin
          if (w_is_stp) begin
            state_q <= S_HALT;
          end else if (w_is_lda || w_is_ldr) begin
            state_q <= S_E2;
          end else if (w_is_mlr && C_MUL_MULTI) begin
            state_q <= S_MULW;
            cnt_q   <= 4'd1;
          end else begin
            state_q <= S_FETCH;
          end
        end
        S_E2: begin
          // ldr always leaves after one cycle; lda waits for memory
          if (w_is_ldr || mem_ready) begin
            state_q <= S_FETCH;
          end
        end
        S_MULW: begin
          if (w_mul_last) begin
            state_q <= S_FETCH;
            cnt_q   <= 4'd0;
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        end
        S_HALT: begin
          state_q <= S_HALT;
        end
        default: begin
          state_q <= S_FETCH;
        end
      endcase
    end
  end

  // Control strobe decode from state and IR; reset forces the FETCH view
  always_comb begin
    fe         = 1'b0;
    e1         = 1'b0;
    e2         = 1'b0;
    instr_rden = 1'b0;
    pc_cnten   = 1'b0;
    pc_sload   = 1'b0;
    data_wren  = 1'b0;
    mux1_sel   = 1'b0;
    mux2_sel   = 1'b0;
    extra1     = 1'b0;
    reg_en     = '0;
    out_sel    = 2'b00;
    halted     = 1'b0;
    imm        = DATA_W'(ir_q[10:0]);

    case (state_q)
      S_FETCH: begin
        fe         = 1'b1;
        instr_rden = 1'b1;
      end
      S_E1: begin
        e1        = 1'b1;
        // Single-cycle instructions advance the PC here; jumps load it
        pc_cnten  = (!w_is_jump && !w_is_stp && !w_is_lda && !w_is_ldr &&
                     !(w_is_mlr && C_MUL_MULTI)) ||
                    (w_is_jeq && !eq_flag) || (w_is_jnq && eq_flag);
        pc_sload  = w_is_jmp || w_is_jmr ||
                    (w_is_jeq && eq_flag) || (w_is_jnq && !eq_flag);
        data_wren = w_is_sta;
        mux1_sel  = w_is_ldi;
        mux2_sel  = w_is_ldr;
        extra1    = w_is_lda || w_is_ldr;
        if (w_is_ldi) begin
          reg_en = NREG'(1) << ir_q[12:11];
        end
        if (w_is_sta) begin
          out_sel = ir_q[12:11];
        end else if (w_is_ldr) begin
          out_sel = ir_q[7:6];
        end
      end
      S_E2: begin
        e2       = 1'b1;
        extra1   = w_is_lda || w_is_ldr;
        pc_cnten = w_is_ldr || (w_is_lda && mem_ready);
        if (w_is_ldr) begin
          reg_en = NREG'(1) << ir_q[10:9];
        end else if (w_is_lda && mem_ready) begin
          reg_en = NREG'(1) << ir_q[12:11];
        end
      end
      S_MULW: begin
        e2       = 1'b1;
        pc_cnten = w_mul_last;
      end
      S_HALT: begin
        halted = 1'b1;
      end
      default: begin
        fe = 1'b0;
      end
    endcase

    // While reset is held the outputs already show the post-reset FETCH view
    if (reset) begin
      fe         = 1'b1;
      e1         = 1'b0;
      e2         = 1'b0;
      instr_rden = 1'b1;
      pc_cnten   = 1'b0;
      pc_sload   = 1'b0;
      data_wren  = 1'b0;
      mux1_sel   = 1'b0;
      mux2_sel   = 1'b0;
      extra1     = 1'b0;
      reg_en     = '0;
      out_sel    = 2'b00;
      halted     = 1'b0;
      imm        = '0;
    end
  end

endmodule
`default_nettype wire

// File: doc/decode_sequencer.md
DECODE_SEQUENCER -- requirements
Module: decode_sequencer

Interface
Parameters:
REQ-001 The block SHALL have parameter DATA_W, default 16, datapath/immediate output width; legal range 11..32.
REQ-002 The block SHALL have parameter MUL_LAT, default 4, mlr execute cycles; legal range 1..15.
REQ-003 The block SHALL have parameter NREG, default 4, register-file enable count; fixed at 4 for the 2-bit reg fields.
Ports:
REQ-004 The block SHALL have port clk  in  1  single clock; all state on rising edge.
REQ-005 The block SHALL have port reset  in  1  synchronous, active-high.
REQ-006 The block SHALL have port instr  in  16  instruction word; opcode = instr[15:11].
REQ-007 The block SHALL have port eq_flag  in  1  ALU equal flag, sampled in E1.
REQ-008 The block SHALL have port mem_ready  in  1  data-memory read-complete handshake.
REQ-009 The block SHALL have ports fe, e1, e2  out  1 each  one-hot phase indicators.
REQ-010 The block SHALL have ports instr_rden, pc_cnten, pc_sload, data_wren, mux1_sel, mux2_sel, extra1  out  1 each  control strobes.
REQ-011 The block SHALL have port reg_en  out  NREG  register write enables, at most one high.
REQ-012 The block SHALL have port imm  out  DATA_W  zero-extended instr[10:0].
REQ-013 The block SHALL have ports out_sel  out  2  register-read mux select; halted  out  1  high in HALT.

Function
REQ-014 The block SHALL implement FSM states FETCH, E1, E2, MULW, HALT; fe=FETCH, e1=E1, e2=E2|MULW.
REQ-015 The block SHALL latch instr into an internal IR on the FETCH->E1 edge; all decode SHALL use IR, not the live instr.
REQ-016 The block SHALL assert instr_rden only in FETCH; data_rden is not generated.
REQ-017 The block SHALL use opcodes: stp 00000; adr..mlr 00001..00111; bfe 0100x; xsl 01010; xsr 01011; bbo 01100; stk 01101; ldr 01110; ldi 100xx; sta 101xx; lda 110xx; jmr 11100; jmp 11101; jeq 11110; jnq 11111.
REQ-018 The block SHALL transition FETCH->E1 always; E1->FETCH for 1-cycle ops (ALU except mlr, ldi, sta, stk, jumps); E1->E2 for lda, ldr; E1->MULW for mlr; E1->HALT for stp.
REQ-019 In MULW the block SHALL count MUL_LAT-1 further cycles, then return to FETCH (mlr total execute = MUL_LAT cycles).
REQ-020 In E2 for lda the block SHALL hold while mem_ready=0 and return to FETCH on the cycle mem_ready=1; ldr SHALL ignore mem_ready and leave after one E2 cycle.
REQ-021 The block SHALL assert pc_cnten exactly once per non-jump, non-stp instruction, in its final execute cycle.
REQ-022 The block SHALL assert pc_sload in E1 for jmp, jmr, jeq with eq_flag=1, jnq with eq_flag=0; a jeq/jnq not taken SHALL assert pc_cnten instead.
REQ-023 The block SHALL never assert pc_cnten and pc_sload together.
REQ-024 The block SHALL assert data_wren in E1 for sta only.
REQ-025 reg_en SHALL be: ldi in E1 -> index IR[12:11]; lda on final E2 cycle -> IR[12:11]; ldr in E2 -> IR[10:9]; else 0.
REQ-026 mux1_sel SHALL equal ldi&E1; mux2_sel SHALL equal ldr&E1; extra1 SHALL be high for lda/ldr in E1 and E2.
REQ-027 imm SHALL equal {zeros, IR[10:0]} in every state; upper DATA_W-11 bits always 0.
REQ-028 out_sel SHALL be IR[12:11] for sta in E1, IR[7:6] for ldr in E1, else 2'b00.
REQ-029 HALT SHALL be absorbing: all strobes 0, halted=1, until reset.
REQ-030 All outputs SHALL be glitch-free functions of registered state and IR (Moore), except pc_sload/pc_cnten in jeq/jnq E1 (depend on eq_flag) and lda exit (depends on mem_ready).

Reset
REQ-031 reset=1 on a rising edge SHALL force state FETCH, IR=0, MULW counter 0, regardless of current state (including mid-MULW, mid-E2 stall, HALT).
REQ-032 During and the cycle after reset, all strobes except fe and instr_rden SHALL be 0; reg_en=0, out_sel=0, imm=0, halted=0.

Verification
REQ-033 Bench SHALL run: ldi r2,#0x5A5 -> FETCH,E1; E1: mux1_sel=1, reg_en=4'b0100, imm=0x05A5, pc_cnten=1.
REQ-034 Bench SHALL run: lda r1 with mem_ready low 3 cycles -> E2 held 3 cycles, then reg_en=4'b0010 and pc_cnten=1 in the single mem_ready=1 cycle.
REQ-035 Bench SHALL run: mlr, MUL_LAT=4 -> e1 1 cycle, e2 3 cycles, pc_cnten only in last; re-run with MUL_LAT=1 -> no MULW.
REQ-036 Bench SHALL run: jeq with eq_flag=1 -> pc_sload=1, pc_cnten=0; eq_flag=0 -> pc_sload=0, pc_cnten=1.
REQ-037 Bench SHALL run: stp -> halted=1 and strobes 0 for 10 cycles; reset asserted mid-MULW and in HALT -> FETCH next cycle, outputs per REQ-032.
REQ-038 Bench SHALL check every cycle: fe/e1/e2 one-hot (or all 0 in HALT), reg_en at most one-hot, pc_cnten&pc_sload never both.
